// File: rtl/spi_rx_pkg.sv
// spi_rx_pkg: shared state/width encodings and the frame-width mask helper for the SPI datapath
package spi_rx_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_DATA = 2'b01, ST_CRC = 2'b10, ST_DONE = 2'b11} rx_state_t;
   typedef enum logic [1:0] {DF_8 = 2'b00, DF_16 = 2'b01, DF_32 = 2'b10, DF_32B = 2'b11} df_t;
   function automatic logic [31:0] df_mask(input logic [1:0] df);
      return (df == DF_8) ? 32'h0000_00FF : (df == DF_16) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
   endfunction
endpackage

// File: rtl/spi_rx_seq_if.sv
// spi_rx_seq_if: control, frame and status bundle between the receive sequencer and its neighbours
interface spi_rx_seq_if #(parameter int PTR_W = 2);
   logic             rx_enable;
   logic [1:0]       df;
   logic             crc_en;
   logic [12:0]      spi_tnum_max;
   logic             frm_vld;
   logic [31:0]      frm_data;
   logic [31:0]      crc_calc;
   logic             rd_en;
   logic             ovr_clr;
   logic             crcerr_clr;
   logic [31:0]      rd_data;
   logic             rxne;
   logic             rx_full;
   logic [PTR_W:0]   fifo_level;
   logic             ovr;
   logic             crcerr;
   logic             crc_init;
   logic             rx_done;
   logic [1:0]       rx_state;
   modport master(
      output rx_enable, df, crc_en, spi_tnum_max, frm_vld, frm_data, crc_calc, rd_en, ovr_clr, crcerr_clr,
      input  rd_data, rxne, rx_full, fifo_level, ovr, crcerr, crc_init, rx_done, rx_state
   );
   modport slave(
      input  rx_enable, df, crc_en, spi_tnum_max, frm_vld, frm_data, crc_calc, rd_en, ovr_clr, crcerr_clr,
      output rd_data, rxne, rx_full, fifo_level, ovr, crcerr, crc_init, rx_done, rx_state
   );
endinterface

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: small synchronous FIFO with zero-latency head read; a push on full only lands if a pop frees the slot
module spi_rx_fifo #(
   parameter int FIFO_DEPTH = 4,
   parameter int PTR_W      = 2
) (
   input  logic             clk_rx,
   input  logic             spi_rx_rstn,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [31:0]      i_data,
   output logic [31:0]      o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [PTR_W:0]   o_level
);
   logic [31:0]      r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_level;
   logic             w_push;
   logic             w_pop;
   assign w_pop   = i_pop && !o_empty;
   assign w_push  = i_push && (!o_full || w_pop);
   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = r_level == (PTR_W+1)'(FIFO_DEPTH);
   assign o_empty = r_level == '0;
   assign o_level = r_level;
   // pointer, occupancy and storage update
   always_ff @(posedge clk_rx or negedge spi_rx_rstn)
      if (!spi_rx_rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) r_mem[r_wr_ptr] <= i_data;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_level <= r_level + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
      end
endmodule

// File: rtl/spi_rx_seq.sv
// spi_rx_seq: frame-level receive sequencer -- counts data frames, checks the trailing CRC frame, raises status
module spi_rx_seq #(
   parameter int FIFO_DEPTH = 4,
   parameter int PTR_W      = 2
) (
   input logic          clk_rx,
   input logic          spi_rx_rstn,
   spi_rx_seq_if.slave  bus
);
   import spi_rx_pkg::*;
   rx_state_t     r_state;
   logic [12:0]   r_cnt;
   logic          r_crc_init;
   logic          r_rx_done;
   logic          r_ovr;
   logic          r_crcerr;
   logic [12:0]   w_max;
   logic          w_last;
   logic          w_push;
   logic          w_full;
   logic          w_empty;
   logic          w_ovr_set;
   logic          w_crc_bad;
   assign w_max     = (bus.spi_tnum_max == '0) ? 13'd1 : bus.spi_tnum_max;
   assign w_last    = ({1'b0, r_cnt} + 14'd1) >= {1'b0, w_max};
   assign w_push    = (r_state == ST_DATA) && bus.rx_enable && bus.frm_vld;
   assign w_ovr_set = w_push && w_full && !bus.rd_en;
   assign w_crc_bad = (r_state == ST_CRC) && bus.rx_enable && bus.frm_vld &&
                      |((bus.frm_data ^ bus.crc_calc) & df_mask(bus.df));
   spi_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_fifo (
      .clk_rx      (clk_rx),
      .spi_rx_rstn (spi_rx_rstn),
      .i_push      (w_push),
      .i_pop       (bus.rd_en),
      .i_data      (bus.frm_data),
      .o_data      (bus.rd_data),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_level     (bus.fifo_level)
   );
   // transfer sequencing: state, frame counter and registered crc_init/rx_done
   always_ff @(posedge clk_rx or negedge spi_rx_rstn)
      if (!spi_rx_rstn) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_crc_init <= 1'b1;
         r_rx_done  <= 1'b0;
      end else if (!bus.rx_enable) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_crc_init <= 1'b1;
         r_rx_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_state    <= ST_DATA;
               r_crc_init <= 1'b0;
            end
            ST_DATA: if (bus.frm_vld) begin
               r_cnt <= r_cnt + 13'd1;
               if (w_last) begin
                  r_state    <= bus.crc_en ? ST_CRC : ST_DONE;
                  r_crc_init <= !bus.crc_en;
                  r_rx_done  <= !bus.crc_en;
               end
            end
            ST_CRC: if (bus.frm_vld) begin
               r_state    <= ST_DONE;
               r_crc_init <= 1'b1;
               r_rx_done  <= 1'b1;
            end
            default: ;
         endcase
      end
   // sticky status flags; a set in the same cycle beats a clear
   always_ff @(posedge clk_rx or negedge spi_rx_rstn)
      if (!spi_rx_rstn) begin
         r_ovr    <= 1'b0;
         r_crcerr <= 1'b0;
      end else begin
         r_ovr    <= w_ovr_set || (r_ovr && !bus.ovr_clr);
         r_crcerr <= w_crc_bad || (r_crcerr && !bus.crcerr_clr);
      end
   assign bus.rxne     = !w_empty;
   assign bus.rx_full  = w_full;
   assign bus.ovr      = r_ovr;
   assign bus.crcerr   = r_crcerr;
   assign bus.crc_init = r_crc_init;
   assign bus.rx_done  = r_rx_done;
   assign bus.rx_state = r_state;
endmodule

// File: tb/tb_spi_rx_seq.sv
// tb_spi_rx_seq: directed vectors against hand-computed expectations for the receive sequencer
module tb_spi_rx_seq;
   logic clk_rx = 1'b0;
   logic spi_rx_rstn = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   spi_rx_seq_if #(.PTR_W(2)) b();
   spi_rx_seq #(.FIFO_DEPTH(4), .PTR_W(2)) dut (
      .clk_rx      (clk_rx),
      .spi_rx_rstn (spi_rx_rstn),
      .bus         (b)
   );
   always #5 clk_rx = ~clk_rx;
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk_rx);
      #1;
   endtask
   task automatic frame(input logic [31:0] d);
      b.frm_vld  = 1'b1;
      b.frm_data = d;
      tick();
      b.frm_vld  = 1'b0;
   endtask
   task automatic pop_chk(input string tag, input logic [31:0] exp);
      chk(tag, b.rd_data, exp);
      b.rd_en = 1'b1;
      tick();
      b.rd_en = 1'b0;
   endtask
   task automatic restart(input logic [1:0] df, input logic [12:0] tnum, input logic crc_en, input logic [31:0] crc);
      b.rx_enable = 1'b0;
      tick();
      b.df = df;
      b.spi_tnum_max = tnum;
      b.crc_en = crc_en;
      b.crc_calc = crc;
      b.rx_enable = 1'b1;
      tick();
   endtask
   initial begin
      b.rx_enable = 0; b.df = 0; b.crc_en = 0; b.spi_tnum_max = 0; b.frm_vld = 0;
      b.frm_data = 0; b.crc_calc = 0; b.rd_en = 0; b.ovr_clr = 0; b.crcerr_clr = 0;
      repeat (2) tick();
      chk("rst_state", 32'(b.rx_state), 32'd0);
      chk("rst_crc_init", 32'(b.crc_init), 32'd1);
      chk("rst_rxne", 32'(b.rxne), 32'd0);
      chk("rst_level", 32'(b.fifo_level), 32'd0);
      chk("rst_flags", {28'd0, b.ovr, b.crcerr, b.rx_done, b.rx_full}, 32'd0);
      chk("rst_rd_data", b.rd_data, 32'd0);
      spi_rx_rstn = 1'b1;
      tick();
      // 8-bit, three frames, no CRC
      restart(2'b00, 13'd3, 1'b0, 32'd0);
      chk("t1_state_data", 32'(b.rx_state), 32'd1);
      chk("t1_crc_init", 32'(b.crc_init), 32'd0);
      frame(32'hA1);
      frame(32'hB2);
      chk("t1_not_done", 32'(b.rx_done), 32'd0);
      frame(32'hC3);
      chk("t1_done", 32'(b.rx_done), 32'd1);
      chk("t1_state_done", 32'(b.rx_state), 32'd3);
      chk("t1_level", 32'(b.fifo_level), 32'd3);
      pop_chk("t1_pop0", 32'hA1);
      pop_chk("t1_pop1", 32'hB2);
      chk("t1_rxne_mid", 32'(b.rxne), 32'd1);
      pop_chk("t1_pop2", 32'hC3);
      chk("t1_rxne_end", 32'(b.rxne), 32'd0);
      // 16-bit with a matching CRC frame (upper bits outside the width must be ignored)
      restart(2'b01, 13'd2, 1'b1, 32'h1D0F);
      frame(32'h1111);
      frame(32'h2222);
      chk("t2_state_crc", 32'(b.rx_state), 32'd2);
      chk("t2_crc_init", 32'(b.crc_init), 32'd0);
      frame(32'hABCD_1D0F);
      chk("t2_crc_masked", 32'(b.crcerr), 32'd0);
      chk("t2_level", 32'(b.fifo_level), 32'd2);
      chk("t2_done", 32'(b.rx_done), 32'd1);
      frame(32'h9999);
      chk("t2_done_ignore", 32'(b.fifo_level), 32'd2);
      pop_chk("t2_pop0", 32'h1111);
      pop_chk("t2_pop1", 32'h2222);
      // 16-bit with a mismatching CRC frame
      restart(2'b01, 13'd2, 1'b1, 32'h1D0F);
      frame(32'h3333);
      frame(32'h4444);
      frame(32'h1D0E);
      chk("t2_crcerr_set", 32'(b.crcerr), 32'd1);
      repeat (3) tick();
      chk("t2_crcerr_sticky", 32'(b.crcerr), 32'd1);
      b.crcerr_clr = 1'b1;
      tick();
      b.crcerr_clr = 1'b0;
      chk("t2_crcerr_clr", 32'(b.crcerr), 32'd0);
      pop_chk("t2_pop2", 32'h3333);
      pop_chk("t2_pop3", 32'h4444);
      // overrun: six frames into four entries
      restart(2'b00, 13'd6, 1'b0, 32'd0);
      for (int i = 1; i <= 4; i++) frame(32'(i));
      chk("t3_full", 32'(b.rx_full), 32'd1);
      chk("t3_no_ovr", 32'(b.ovr), 32'd0);
      frame(32'd5);
      chk("t3_ovr", 32'(b.ovr), 32'd1);
      chk("t3_not_done", 32'(b.rx_done), 32'd0);
      frame(32'd6);
      chk("t3_done", 32'(b.rx_done), 32'd1);
      chk("t3_level", 32'(b.fifo_level), 32'd4);
      for (int i = 1; i <= 4; i++) pop_chk("t3_pop", 32'(i));
      b.ovr_clr = 1'b1;
      tick();
      b.ovr_clr = 1'b0;
      chk("t3_ovr_clr", 32'(b.ovr), 32'd0);
      // simultaneous push and pop on a full FIFO, then on an empty one
      restart(2'b00, 13'd8, 1'b0, 32'd0);
      for (int i = 16; i < 20; i++) frame(32'(i));
      b.rd_en = 1'b1;
      frame(32'h14);
      b.rd_en = 1'b0;
      chk("t4_head", b.rd_data, 32'h11);
      chk("t4_level", 32'(b.fifo_level), 32'd4);
      chk("t4_no_ovr", 32'(b.ovr), 32'd0);
      pop_chk("t4_pop0", 32'h11);
      pop_chk("t4_pop1", 32'h12);
      pop_chk("t4_pop2", 32'h13);
      pop_chk("t4_tail", 32'h14);
      b.rd_en = 1'b1;
      frame(32'h55);
      b.rd_en = 1'b0;
      chk("t4_empty_pp_level", 32'(b.fifo_level), 32'd1);
      pop_chk("t4_empty_pp_data", 32'h55);
      // enable dropped mid-transfer
      restart(2'b00, 13'd5, 1'b0, 32'd0);
      frame(32'h21);
      frame(32'h22);
      b.rx_enable = 1'b0;
      tick();
      chk("t5_idle", 32'(b.rx_state), 32'd0);
      chk("t5_crc_init", 32'(b.crc_init), 32'd1);
      chk("t5_level_kept", 32'(b.fifo_level), 32'd2);
      pop_chk("t5_pop0", 32'h21);
      pop_chk("t5_pop1", 32'h22);
      b.rx_enable = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) frame(32'h31 + 32'(i));
      chk("t5_not_done", 32'(b.rx_done), 32'd0);
      frame(32'h35);
      chk("t5_done", 32'(b.rx_done), 32'd1);
      chk("t5_ovr", 32'(b.ovr), 32'd1);
      b.ovr_clr = 1'b1;
      tick();
      b.ovr_clr = 1'b0;
      for (int i = 0; i < 4; i++) pop_chk("t5_pop", 32'h31 + 32'(i));
      // 32-bit CRC, then set-beats-clear with tnum=0 treated as one frame
      restart(2'b10, 13'd1, 1'b1, 32'hDEADBEEF);
      frame(32'h01);
      chk("t6_state_crc", 32'(b.rx_state), 32'd2);
      frame(32'hDEADBEEF);
      chk("t6_crc_ok", 32'(b.crcerr), 32'd0);
      chk("t6_crc_not_pushed", 32'(b.fifo_level), 32'd1);
      pop_chk("t6_pop0", 32'h01);
      restart(2'b11, 13'd0, 1'b1, 32'hDEADBEEF);
      frame(32'h02);
      chk("t6_tnum0_crc", 32'(b.rx_state), 32'd2);
      b.crcerr_clr = 1'b1;
      frame(32'hDEADBEEE);
      b.crcerr_clr = 1'b0;
      chk("t6_set_wins", 32'(b.crcerr), 32'd1);
      chk("t6_done", 32'(b.rx_done), 32'd1);
      pop_chk("t6_pop1", 32'h02);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
